sipo_frame_ctrl: RTL and testbench

Sequencing controller for an 8-bit serial-in/parallel-out shift register that has a clock enable. It gates the shifter's enable from a framed serial bit stream and counts bits into words. It captures each completed word into a holding register with a valid/ready output handshake, and flags overruns and aborted frames. It sits between the serial pin logic and the parallel consumer, with the enabled SIPO instantiated beside it at top level.

---
 rtl/sipo_frame_ctrl_pkg.sv | 20 ++
 rtl/sipo_out_hold.sv | 61 ++++++
 rtl/sipo_frame_ctrl.sv | 142 ++++++++++++++
 tb/tb_sipo_frame_ctrl.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_frame_ctrl_pkg.sv
// sipo_frame_ctrl_pkg
// Shared definitions for the SIPO frame controller: the controller state
// encoding, the default word width and a helper that sizes the bit counter.
package sipo_frame_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  // The counter must be able to hold the value WIDTH, so it needs
  // clog2(WIDTH+1) bits rather than clog2(WIDTH).
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_out_hold.sv
// sipo_out_hold
// Holding register between the SIPO and the parallel consumer. It loads a
// completed word on 'capture' when the register is empty or is being emptied
// in the same cycle. Otherwise it drops the word and sets the sticky
// overrun flag.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   capture    : a completed word is present on data_in this cycle
//   data_in    : parallel word from the SIPO
//   o_ready    : consumer accepts o_data when o_valid & o_ready
//   clr_err    : synchronous clear of overrun (a new overrun wins)
//   o_data     : held word
//   o_valid    : o_data holds an unconsumed word
//   overrun    : sticky, a completed word was dropped
module sipo_out_hold #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             capture,
  input  logic [WIDTH-1:0] data_in,
  input  logic             o_ready,
  input  logic             clr_err,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             overrun
);

  logic can_load;
  logic drop;

  // The register can be refilled either when it is empty or when its current
  // word leaves on this same edge.
  assign can_load = !o_valid || o_ready;
  assign drop     = capture && !can_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_data  <= '0;
      o_valid <= 1'b0;
    end else if (capture && can_load) begin
      o_data  <= data_in;
      o_valid <= 1'b1;
    end else if (o_valid && o_ready) begin
      o_valid <= 1'b0;
    end
  end

  // A drop that coincides with clr_err keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clr_err) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl
// Sequencing controller for an external enabled SIPO shift register. It gates
// the SIPO clock enable from a framed serial strobe and counts bits into
// words. When a word completes, it captures the SIPO's parallel output into a
// valid/ready holding register. It reports overruns and aborted partial
// frames.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   frame      : high while a frame is in progress, low aborts a partial word
//   si_valid   : the SIPO serial input carries a valid bit this cycle
//   shift_en   : combinational clock enable to the SIPO
//   par_in     : parallel output of the SIPO
//   o_data     : captured word
//   o_valid    : o_data holds an unconsumed word
//   o_ready    : consumer handshake
//   overrun    : sticky, a completed word was dropped
//   abort      : one-cycle pulse, a frame ended with a partial word
//   clr_err    : synchronous clear of overrun
//   bit_cnt    : bits accepted into the current word
module sipo_frame_ctrl
  import sipo_frame_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        frame,
  input  logic                        si_valid,
  output logic                        shift_en,
  input  logic [WIDTH-1:0]            par_in,
  output logic [WIDTH-1:0]            o_data,
  output logic                        o_valid,
  input  logic                        o_ready,
  output logic                        overrun,
  output logic                        abort,
  input  logic                        clr_err,
  output logic [cnt_width(WIDTH)-1:0] bit_cnt
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          abort_q;
  logic          abort_next;
  logic          accept;
  logic          capture;

  // A bit is taken whenever the frame is open and the strobe is present,
  // regardless of state. This lets the first bit of the next word enter the
  // SIPO during CAPTURE. The enable is forced low while reset is asserted.
  assign accept   = frame && si_valid;
  assign shift_en = accept && rst_n;

  // The SIPO output is complete one cycle after its last shift edge, which is
  // exactly the CAPTURE cycle.
  assign capture  = (state == CAPTURE);

  assign bit_cnt  = cnt;
  assign abort    = abort_q;

  // State, bit counter and abort pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      abort_q <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      abort_q <= abort_next;
    end
  end

  // Next-state logic. The abort pulse is raised only when a frame closes with
  // a partial word. A frame that ends in CAPTURE has a complete word, so it
  // does not abort.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    abort_next = 1'b0;
    case (state)
      IDLE: begin
        if (frame) begin
          state_next = SHIFT;
          cnt_next   = accept ? CW'(1) : '0;
        end else begin
          cnt_next   = '0;
        end
      end
      SHIFT: begin
        if (!frame) begin
          state_next = IDLE;
          cnt_next   = '0;
          abort_next = (cnt != '0);
        end else if (accept) begin
          if (cnt == LAST_BIT) begin
            state_next = CAPTURE;
            cnt_next   = '0;
          end else begin
            cnt_next   = cnt + CW'(1);
          end
        end
      end
      CAPTURE: begin
        if (accept) begin
          state_next = SHIFT;
          cnt_next   = CW'(1);
        end else if (frame) begin
          state_next = SHIFT;
          cnt_next   = '0;
        end else begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  sipo_out_hold #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .capture (capture),
    .data_in (par_in),
    .o_ready (o_ready),
    .clr_err (clr_err),
    .o_data  (o_data),
    .o_valid (o_valid),
    .overrun (overrun)
  );

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// tb_sipo_frame_ctrl
// Bench for sipo_frame_ctrl. It includes a behavioural enabled SIPO that
// feeds par_in, and a cycle-level reference model. The model counts accepted
// bits into words and applies the holding register rules to the completed
// words.
module tb_sipo_frame_ctrl;
  import sipo_frame_ctrl_pkg::*;

  localparam int W = 8;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b0;
  logic         frame    = 1'b0;
  logic         si_valid = 1'b0;
  logic         si       = 1'b0;
  logic         o_ready  = 1'b0;
  logic         clr_err  = 1'b0;
  logic         shift_en;
  logic [W-1:0] par_in;
  logic [W-1:0] o_data;
  logic         o_valid;
  logic         overrun;
  logic         abort;
  logic [3:0]   bit_cnt;
  logic [W-1:0] sipo;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int           m_bits;
  logic [W-1:0] m_acc;
  logic [W-1:0] m_capw;
  logic [W-1:0] m_data;
  logic         m_cap;
  logic         m_valid;
  logic         m_over;
  logic         m_abort;

  always #5 clk = ~clk;

  // Enabled SIPO beside the controller, MSB first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sipo <= '0;
    else if (shift_en) sipo <= {sipo[W-2:0], si};
  end
  assign par_in = sipo;

  sipo_frame_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .frame    (frame),
    .si_valid (si_valid),
    .shift_en (shift_en),
    .par_in   (par_in),
    .o_data   (o_data),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .overrun  (overrun),
    .abort    (abort),
    .clr_err  (clr_err),
    .bit_cnt  (bit_cnt)
  );

  // Model reset: no bits, empty holding register, no flags
  task automatic model_reset();
    m_bits  = 0;
    m_acc   = '0;
    m_capw  = '0;
    m_data  = '0;
    m_cap   = 1'b0;
    m_valid = 1'b0;
    m_over  = 1'b0;
    m_abort = 1'b0;
  endtask

  // Model one rising edge from the current inputs. A word completed on the
  // previous edge is offered to the holding register on this edge.
  task automatic model_edge();
    logic ovf;
    ovf = m_cap && m_valid && !o_ready;
    if (m_cap && !ovf) begin
      m_data  = m_capw;
      m_valid = 1'b1;
    end else if (m_valid && o_ready) begin
      m_valid = 1'b0;
    end
    if (ovf) m_over = 1'b1;
    else if (clr_err) m_over = 1'b0;
    m_abort = !frame && (m_bits != 0);
    m_cap = 1'b0;
    if (!frame) begin
      m_bits = 0;
    end else if (si_valid) begin
      m_acc = {m_acc[W-2:0], si};
      m_bits++;
      if (m_bits == W) begin
        m_cap  = 1'b1;
        m_capw = m_acc;
        m_bits = 0;
      end
    end
  endtask

  task automatic applyStimulus(input logic f, input logic v, input logic b,
                               input logic r, input logic c);
    frame    = f;
    si_valid = v;
    si       = b;
    o_ready  = r;
    clr_err  = c;
    #1;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic r);
    for (int i = W - 1; i >= 0; i--) begin
      applyStimulus(1'b1, 1'b1, w[i], r, 1'b0);
      tick();
    end
  endtask

  // Reset state, reset in the middle of a word, then recovery with 0xA5.
  task automatic test_reset();
    logic [W-1:0] w;
    w = 8'hA5;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({o_valid, o_data, overrun, abort, bit_cnt, shift_en} !== 15'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: got v=%0b d=%h ov=%0b ab=%0b cnt=%0d se=%0b expected all zero",
               o_valid, o_data, overrun, abort, bit_cnt, shift_en);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 1'(i), 1'b1, 1'b0);
      tick();
    end
    checks++;
    if (bit_cnt !== 4'd5) begin
      errors++;
      $display("[TB] FAIL pre_reset_cnt: got %0d expected 5", bit_cnt);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (bit_cnt !== 4'd0 || o_valid !== 1'b0 || shift_en !== 1'b0 || dut.state !== IDLE) begin
      errors++;
      $display("[TB] FAIL midword_reset: got cnt=%0d v=%0b se=%0b st=%0d expected 0 0 0 IDLE",
               bit_cnt, o_valid, shift_en, dut.state);
    end
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    send_word(w, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL reset_recover: got v=%0b d=%h expected 1 a5", o_valid, o_data);
    end
  endtask

  // One word, 0x3C. It appears two cycles after its last bit's cycle.
  task automatic test_single();
    logic [W-1:0] w;
    int se_low;
    w = 8'h3C;
    se_low = 0;
    drain();
    for (int i = W - 1; i >= 0; i--) begin
      applyStimulus(1'b1, 1'b1, w[i], 1'b1, 1'b0);
      if (shift_en !== 1'b1) se_low++;
      tick();
    end
    checks++;
    if (se_low != 0 || o_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_early: got se_low=%0d v=%0b expected 0 0", se_low, o_valid);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h3C || abort !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_word: got v=%0b d=%h ab=%0b ov=%0b expected 1 3c 0 0",
               o_valid, o_data, abort, overrun);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    checks++;
    if (o_valid !== 1'b0 || abort !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_consume: got v=%0b ab=%0b expected 0 0", o_valid, abort);
    end
  endtask

  // 16 back-to-back bits: 0x81 then 0x7E with beats eight cycles apart.
  task automatic test_back_to_back();
    logic [15:0] s;
    int beats;
    int se;
    s = 16'h817E;
    beats = 0;
    se = 0;
    drain();
    for (int k = 0; k < 18; k++) begin
      if (k < 16) applyStimulus(1'b1, 1'b1, s[15-k], 1'b1, 1'b0);
      else applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      if (k < 16 && shift_en === 1'b1) se++;
      tick();
      if (o_valid === 1'b1) begin
        beats++;
        checks++;
        if ((beats == 1 && (k != 8 || o_data !== 8'h81)) ||
            (beats == 2 && (k != 16 || o_data !== 8'h7E)) || beats > 2) begin
          errors++;
          $display("[TB] FAIL b2b_beat%0d: got cycle=%0d d=%h expected cycle=%0d d=%h",
                   beats, k + 1, o_data, (beats == 1) ? 9 : 17, (beats == 1) ? 8'h81 : 8'h7E);
        end
      end
    end
    checks++;
    if (beats != 2 || se != 16) begin
      errors++;
      $display("[TB] FAIL b2b_totals: got beats=%0d shift_en_cycles=%0d expected 2 16", beats, se);
    end
  endtask

  // Overrun on a second unconsumed word, clear, then set-wins-over-clear.
  task automatic test_overrun();
    drain();
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h11 || overrun !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overrun_set: got v=%0b d=%h ov=%0b expected 1 11 1", o_valid, o_data, overrun);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    checks++;
    if (overrun !== 1'b0 || o_data !== 8'h11) begin
      errors++;
      $display("[TB] FAIL overrun_clear: got ov=%0b d=%h expected 0 11", overrun, o_data);
    end
    send_word(8'h33, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (overrun !== 1'b1 || o_data !== 8'h11) begin
      errors++;
      $display("[TB] FAIL overrun_setwins: got ov=%0b d=%h expected 1 11", overrun, o_data);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    checks++;
    if (o_valid !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overrun_drain: got v=%0b ov=%0b expected 0 0", o_valid, overrun);
    end
  endtask

  // Partial frame gives an abort pulse. A frame closing in CAPTURE delivers
  // its word without an abort.
  task automatic test_abort();
    drain();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'(~i), 1'b1, 1'b0);
      tick();
    end
    checks++;
    if (bit_cnt !== 4'd3) begin
      errors++;
      $display("[TB] FAIL abort_precnt: got %0d expected 3", bit_cnt);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    checks++;
    if (abort !== 1'b1 || bit_cnt !== 4'd0 || o_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_pulse: got ab=%0b cnt=%0d v=%0b expected 1 0 0", abort, bit_cnt, o_valid);
    end
    tick();
    checks++;
    if (abort !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_width: got %0b expected 0", abort);
    end
    send_word(8'h5A, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h5A || abort !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_in_capture: got v=%0b d=%h ab=%0b expected 1 5a 0", o_valid, o_data, abort);
    end
    tick();
    checks++;
    if (abort !== 1'b0 || dut.state !== IDLE) begin
      errors++;
      $display("[TB] FAIL abort_after_capture: got ab=%0b st=%0d expected 0 IDLE", abort, dut.state);
    end
  endtask

  // 0xC3 with random 0..3 cycle strobe gaps. The count holds during gaps.
  task automatic test_gapped();
    logic [W-1:0] w;
    int sent;
    int bad;
    int gaps;
    w = 8'hC3;
    sent = 0;
    bad = 0;
    drain();
    for (int i = W - 1; i >= 0; i--) begin
      gaps = $urandom_range(0, 3);
      repeat (gaps) begin
        applyStimulus(1'b1, 1'b0, 1'($urandom), 1'b1, 1'b0);
        if (shift_en !== 1'b0) bad++;
        tick();
        if (bit_cnt !== 4'(sent)) bad++;
      end
      applyStimulus(1'b1, 1'b1, w[i], 1'b1, 1'b0);
      tick();
      sent++;
      if (sent < W && bit_cnt !== 4'(sent)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL gapped_hold: got %0d bad count/enable cycles expected 0", bad);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'hC3) begin
      errors++;
      $display("[TB] FAIL gapped_word: got v=%0b d=%h expected 1 c3", o_valid, o_data);
    end
  endtask

  // Random frames, strobes, ready and clear, compared with the model every cycle.
  task automatic test_random();
    logic f;
    logic v;
    int bad;
    bad = 0;
    drain();
    for (int n = 0; n < 600; n++) begin
      f = ($urandom_range(0, 19) != 0);
      v = ($urandom_range(0, 3) != 0);
      applyStimulus(f, v, 1'($urandom), ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
      if (shift_en !== (f && v)) bad++;
      tick();
      checks++;
      if ({o_valid, o_data, overrun, abort, bit_cnt} !== {m_valid, m_data, m_over, m_abort, 4'(m_bits)}) begin
        errors++;
        $display("[TB] FAIL random_cycle%0d: got v=%0b d=%h ov=%0b ab=%0b cnt=%0d expected v=%0b d=%h ov=%0b ab=%0b cnt=%0d",
                 n, o_valid, o_data, overrun, abort, bit_cnt, m_valid, m_data, m_over, m_abort, m_bits);
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL random_shift_en: got %0d wrong enable cycles expected 0", bad);
    end
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_abort();
    test_gapped();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
